// File: rtl/reg_dump_pkg.sv
// Shared types and helpers for the debug register dump UART.
// Holds the FSM state set, the default frame header and frame sizing.
package reg_dump_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [7:0] HEADER_DEFAULT = 8'hA5;

  // Header byte + 4 PC bytes + 4 bytes per dumped register.
  function automatic int frame_bytes(input int n);
    return 5 + 4 * n;
  endfunction

  // Big-endian byte pick: lane 0 is bits [31:24].
  function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] lane);
    logic [7:0] b;
    case (lane)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 UART transmitter: tx falls on the edge that accepts a byte, 10*CLKS_PER_BIT cycles per byte.
// ready is high when idle and in the final cycle of the stop bit, so bytes can run back-to-back.
module uart_tx_byte #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       tx
);

  localparam int              TW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0]   TMR_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]      BIT_STOP = 4'd9;

  logic          r_active;
  logic [TW-1:0] r_tmr;
  logic [3:0]    r_bit;
  logic [7:0]    r_shift;
  logic          r_tx;

  logic w_bit_end;
  logic w_accept;

  assign w_bit_end = (r_tmr == TMR_LAST);
  assign ready     = !r_active || (w_bit_end && (r_bit == BIT_STOP));
  assign w_accept  = valid && ready;
  assign tx        = r_tx;

  // r_bit: 0 = start bit, 1..8 = data bits d[0]..d[7], 9 = stop bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_active <= 1'b0;
      r_tmr    <= '0;
      r_bit    <= '0;
      r_shift  <= '0;
      r_tx     <= 1'b1;
    end else if (w_accept) begin
      r_active <= 1'b1;
      r_tmr    <= '0;
      r_bit    <= '0;
      r_shift  <= data;
      r_tx     <= 1'b0;
    end else if (r_active) begin
      if (w_bit_end) begin
        r_tmr <= '0;
        if (r_bit == BIT_STOP) begin
          r_active <= 1'b0;
        end else begin
          r_bit <= r_bit + 4'd1;
          r_tx  <= (r_bit == 4'd8) ? 1'b1 : r_shift[r_bit[2:0]];
        end
      end else begin
        r_tmr <= r_tmr + TW'(1);
      end
    end
  end

endmodule

// File: rtl/reg_dump_uart.sv
// Dumps fetch_pc and debug registers 0..NUM_REGS-1 as one UART frame; tx falls 2 cycles after start.
// No backpressure: start is taken only in IDLE, other starts are dropped.
module reg_dump_uart
  import reg_dump_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 868,
  parameter int          NUM_REGS     = 32,
  parameter logic [7:0]  HEADER       = HEADER_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] fetch_pc,
  input  logic [31:0] debug_reg_out,
  output logic [4:0]  debug_reg_select,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  localparam logic [7:0] FRAME_LEN = 8'(frame_bytes(NUM_REGS));
  localparam logic [4:0] SEL_LAST  = 5'(NUM_REGS - 1);
  localparam logic [7:0] FIRST_REG = 8'd5;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_word;
  logic [7:0]  r_byte_cnt;
  logic [4:0]  r_sel;
  logic        r_busy;
  logic        r_done;

  logic [1:0]  w_lane;
  logic        w_in_regs;
  logic        w_word_start;
  logic        w_byte_vld;
  logic [7:0]  w_byte_dat;
  logic        w_tx_rdy;

  // r_byte_cnt is the index of the next byte to hand over; PC and register
  // bytes both sit at (index - 1) mod 4 within their word.
  assign w_lane       = r_byte_cnt[1:0] - 2'd1;
  assign w_in_regs    = (r_byte_cnt >= FIRST_REG);
  assign w_word_start = w_in_regs && (w_lane == 2'd0);

  // From the second register on, byte 0 is taken straight from the core port
  // on the same edge that refreshes r_word, so words follow with no gap.
  always_comb begin
    w_byte_vld = 1'b0;
    w_byte_dat = HEADER;
    case (r_state)
      LOAD: begin
        w_byte_vld = 1'b1;
        w_byte_dat = HEADER;
      end
      SEND: begin
        w_byte_vld = (r_byte_cnt != FRAME_LEN);
        if (!w_in_regs) begin
          w_byte_dat = word_byte(r_pc, w_lane);
        end else if (w_word_start && (r_byte_cnt != FIRST_REG)) begin
          w_byte_dat = debug_reg_out[31:24];
        end else begin
          w_byte_dat = word_byte(r_word, w_lane);
        end
      end
      default: begin
        w_byte_vld = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_pc       <= '0;
      r_word     <= '0;
      r_byte_cnt <= '0;
      r_sel      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_pc       <= fetch_pc;
            r_sel      <= '0;
            r_busy     <= 1'b1;
            r_byte_cnt <= '0;
            r_state    <= LOAD;
          end
        end
        LOAD: begin
          // Transmitter is idle here, so the header is accepted this cycle.
          r_word     <= debug_reg_out;
          r_byte_cnt <= 8'd1;
          r_state    <= SEND;
        end
        SEND: begin
          if (w_tx_rdy) begin
            if (r_byte_cnt == FRAME_LEN) begin
              r_byte_cnt <= '0;
              r_busy     <= 1'b0;
              r_done     <= 1'b1;
              r_state    <= DONE;
            end else begin
              r_byte_cnt <= r_byte_cnt + 8'd1;
              if (w_word_start) begin
                if (r_byte_cnt != FIRST_REG) begin
                  r_word <= debug_reg_out;
                end
                if (r_sel != SEL_LAST) begin
                  r_sel <= r_sel + 5'd1;
                end
              end
            end
          end
        end
        DONE: begin
          r_sel   <= '0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk   (clk),
    .reset (reset),
    .data  (w_byte_dat),
    .valid (w_byte_vld),
    .ready (w_tx_rdy),
    .tx    (tx)
  );

  assign debug_reg_select = r_sel;
  assign busy             = r_busy;
  assign done             = r_done;

endmodule

// File: tb/tb_reg_dump_uart.sv
// Scoreboard bench: stimulus queues expected frame bytes, per-instance UART monitors decode tx and compare.
// Instance A: 4 clocks/bit, 32 registers. Instance B: 2 clocks/bit, 1 register.
module tb_reg_dump_uart;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  rst;
  logic [1:0]  start;
  logic [31:0] pc_a, pc_b;
  logic [31:0] dro_a, dro_b;
  wire  [4:0]  sel_a, sel_b;
  wire  [1:0]  tx_w, busy_w, done_w;

  logic [31:0] regs [32];
  assign dro_a = regs[sel_a];
  assign dro_b = regs[sel_b];

  logic [7:0] q_a [$];
  logic [7:0] q_b [$];
  int rx_cnt [2];
  int tests = 0;
  int fails = 0;

  reg_dump_uart #(.CLKS_PER_BIT(4), .NUM_REGS(32)) u_a (
    .clk(clk), .reset(rst[0]), .start(start[0]), .fetch_pc(pc_a),
    .debug_reg_out(dro_a), .debug_reg_select(sel_a),
    .tx(tx_w[0]), .busy(busy_w[0]), .done(done_w[0]));

  reg_dump_uart #(.CLKS_PER_BIT(2), .NUM_REGS(1)) u_b (
    .clk(clk), .reset(rst[1]), .start(start[1]), .fetch_pc(pc_b),
    .debug_reg_out(dro_b), .debug_reg_select(sel_b),
    .tx(tx_w[1]), .busy(busy_w[1]), .done(done_w[1]));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] sel_of(input int inst);
    return (inst != 0) ? sel_b : sel_a;
  endfunction

  task automatic push_byte(input int inst, input logic [7:0] b);
    if (inst != 0) q_b.push_back(b);
    else           q_a.push_back(b);
  endtask

  // Expected frame uses the hand formula R[k] = 0x1000_0000 + k.
  task automatic push_frame(input int inst, input logic [31:0] pc, input int nregs);
    logic [31:0] r;
    push_byte(inst, 8'hA5);
    for (int i = 0; i < 4; i++) push_byte(inst, pc[31 - 8*i -: 8]);
    for (int k = 0; k < nregs; k++) begin
      r = 32'h1000_0000 + 32'(k);
      for (int i = 0; i < 4; i++) push_byte(inst, r[31 - 8*i -: 8]);
    end
  endtask

  task automatic monitor(input int inst, input int c_bit);
    logic [9:0] bits;
    logic       first, ok, ab, pending;
    logic [7:0] exp_b;
    int         qs;
    pending = 1'b0;
    forever begin
      if (!pending) begin
        @(negedge clk);
        if (rst[inst] || tx_w[inst]) continue;
      end
      pending = 1'b0;
      ab = 1'b0;
      ok = 1'b1;
      bits = '0;
      first = 1'b0;
      for (int b = 0; b < 10 && !ab; b++) begin
        for (int c = 0; c < c_bit && !ab; c++) begin
          if (b != 0 || c != 0) begin
            @(negedge clk);
            if (rst[inst]) ab = 1'b1;
          end
          if (!ab) begin
            if (c == 0) first = tx_w[inst];
            else if (tx_w[inst] !== first) ok = 1'b0;
            if (c == c_bit / 2) bits[b] = tx_w[inst];
          end
        end
      end
      if (ab) continue;
      check($sformatf("uart_frame%0d{const,start,stop}", inst), {61'd0, ok, bits[0], bits[9]}, 64'b101);
      qs = (inst != 0) ? q_b.size() : q_a.size();
      check($sformatf("byte_expected%0d", inst), 64'(qs > 0), 64'd1);
      if (qs > 0) begin
        exp_b = (inst != 0) ? q_b.pop_front() : q_a.pop_front();
        check($sformatf("rx_byte%0d[%0d]", inst, rx_cnt[inst]), 64'(bits[8:1]), 64'(exp_b));
      end
      rx_cnt[inst]++;
      qs = (inst != 0) ? q_b.size() : q_a.size();
      if (qs > 0) begin
        @(negedge clk);
        if (!rst[inst]) begin
          check($sformatf("back_to_back%0d", inst), 64'(tx_w[inst]), 64'd0);
          pending = (tx_w[inst] == 1'b0);
        end
      end
    end
  endtask

  initial monitor(0, 4);
  initial monitor(1, 2);

  task automatic pulse_start(input int inst, input logic [31:0] pc);
    @(posedge clk); #1;
    if (inst != 0) pc_b = pc; else pc_a = pc;
    start[inst] = 1'b1;
    @(posedge clk); #1;
    start[inst] = 1'b0;
  endtask

  // n counts cycles from the accepting edge: n=1 is LOAD, tx low at n=2, done at n=2+frame.
  task automatic run_frame(input int inst, input logic [31:0] pc, input int nregs,
                           input int c_bit, input bit extra_starts, input bit mod_r3);
    int frame_cyc, busy_cnt, done_cnt, done_n, start_clr;
    bit changed;
    frame_cyc = (5 + 4*nregs) * 10 * c_bit;
    busy_cnt = 0; done_cnt = 0; done_n = -1; start_clr = -1; changed = 0;
    push_frame(inst, pc, nregs);
    rx_cnt[inst] = 0;
    pulse_start(inst, pc);
    for (int n = 1; n <= frame_cyc + 60; n++) begin
      @(negedge clk);
      if (n == 1) check($sformatf("load_cycle%0d{tx,busy}", inst), {62'd0, tx_w[inst], busy_w[inst]}, 64'b11);
      if (n == 2) check($sformatf("tx_fall_n2_%0d", inst), 64'(tx_w[inst]), 64'd0);
      if (busy_w[inst]) busy_cnt++;
      if (done_w[inst]) begin
        done_cnt++;
        if (done_n < 0) done_n = n;
        if (extra_starts) begin
          start[inst] = 1'b1;
          start_clr = n + 1;
        end
      end
      if (extra_starts && (n == 10 || n == 2000)) begin
        start[inst] = 1'b1;
        start_clr = n + 1;
      end
      if (n == start_clr) start[inst] = 1'b0;
      if (mod_r3 && !changed && sel_of(inst) == 5'd4) begin
        regs[3] = 32'hDEAD_BEEF;
        changed = 1;
      end
    end
    start[inst] = 1'b0;
    check($sformatf("done_cycle%0d", inst), 64'(done_n), 64'(2 + frame_cyc));
    check($sformatf("done_pulses%0d", inst), 64'(done_cnt), 64'd1);
    check($sformatf("busy_cycles%0d", inst), 64'(busy_cnt), 64'(frame_cyc + 1));
    check($sformatf("byte_count%0d", inst), 64'(rx_cnt[inst]), 64'(5 + 4*nregs));
    check($sformatf("queue_drained%0d", inst), 64'((inst != 0) ? q_b.size() : q_a.size()), 64'd0);
    check($sformatf("sel_back_to_0_%0d", inst), 64'(sel_of(inst)), 64'd0);
    if (mod_r3) begin
      check("r3_model_changed", 64'(changed), 64'd1);
      regs[3] = 32'h1000_0003;
    end
  endtask

  task automatic reset_mid_frame();
    int guard, done_cnt, tx_low;
    push_frame(0, 32'h0000_0040, 32);
    rx_cnt[0] = 0;
    pulse_start(0, 32'h0000_0040);
    guard = 0;
    while (rx_cnt[0] < 50 && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    check("reached_byte50", 64'(rx_cnt[0] >= 50), 64'd1);
    repeat (20) @(negedge clk);
    @(posedge clk); #1; rst[0] = 1'b1;
    @(posedge clk); #1; rst[0] = 1'b0;
    q_a.delete();
    @(negedge clk);
    check("after_reset{tx,busy,done,sel}", {56'd0, tx_w[0], busy_w[0], done_w[0], sel_a}, {56'd0, 3'b100, 5'd0});
    done_cnt = 0; tx_low = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (done_w[0]) done_cnt++;
      if (!tx_w[0] || busy_w[0]) tx_low++;
    end
    check("no_done_after_reset", 64'(done_cnt), 64'd0);
    check("line_idle_after_reset", 64'(tx_low), 64'd0);
  endtask

  initial begin
    for (int k = 0; k < 32; k++) regs[k] = 32'h1000_0000 + 32'(k);
    rx_cnt[0] = 0; rx_cnt[1] = 0;
    rst = 2'b11; start = 2'b00; pc_a = '0; pc_b = '0;
    repeat (3) @(posedge clk);
    #1 rst = 2'b00;

    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      check("idle_a{tx,busy,done,sel}", {56'd0, tx_w[0], busy_w[0], done_w[0], sel_a}, {56'd0, 3'b100, 5'd0});
      check("idle_b{tx,busy,done,sel}", {56'd0, tx_w[1], busy_w[1], done_w[1], sel_b}, {56'd0, 3'b100, 5'd0});
    end

    run_frame(0, 32'h0000_0040, 32, 4, 1'b0, 1'b0);
    run_frame(0, 32'hCAFE_0123, 32, 4, 1'b1, 1'b1);
    reset_mid_frame();
    run_frame(0, 32'h8000_00FC, 32, 4, 1'b0, 1'b0);
    run_frame(1, 32'h1234_5678, 1, 2, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, %0d tests run", tests);
    $fatal(1, "watchdog");
  end

endmodule
